// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: one-stage registered opcode decoder with stall, flush,
// sticky illegal-opcode flag and a squash counter that kills slots after control transfers.
`default_nettype none

module pipelined_control_unit #(
  parameter int OPCODE_W      = 4,
  parameter int ALU_OP_W      = 4,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  output logic                out_valid,
  output logic                reg_dst,
  output logic                jump,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic                reg_write,
  output logic                beq,
  output logic                bne,
  output logic [1:0]          mem_op,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic                squashing
);

  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic       beq;
    logic       bne;
    logic [1:0] mem_op;
    logic [3:0] alu;
  } ctrl_t;

  localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_CYCLES);

  logic       opcode_high;
  logic [3:0] op4;
  ctrl_t      dec;
  ctrl_t      ctrl_q;
  logic       valid_q;
  logic [2:0] squash_cnt;
  logic       accept;
  logic       legal_accept;
  logic       squash_load;

  // Only opcodes wider than 4 bits can encode values outside the table.
  generate
    if (OPCODE_W > 4) begin : g_wide_opcode
      assign opcode_high = |opcode[OPCODE_W-1:4];
    end else begin : g_narrow_opcode
      assign opcode_high = 1'b0;
    end
  endgenerate

  assign op4 = opcode[3:0];

  always_comb begin
    dec = '0;
    case (op4)
      4'd0:                         begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu = 4'd0; end
      4'd1:                         begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu = 4'd0; end
      4'd2:                         begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu = 4'd1; end
      4'd3:                         begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu = 4'd1; end
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu = op4 - 4'd2; end
      4'd9:                         begin dec.reg_write = 1'b1; dec.alu = 4'd7; end
      4'd10:                        begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu = 4'd8; end
      4'd11: begin
        dec.mem_op     = 2'b01;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
      end
      4'd12:                        begin dec.mem_op = 2'b10; dec.alu_src = 1'b1; end
      4'd13:                        begin dec.beq = 1'b1; dec.alu = 4'd1; end
      4'd14:                        begin dec.bne = 1'b1; dec.alu = 4'd1; end
      default:                      dec.jump = 1'b1;
    endcase
  end

  assign accept       = in_valid & ~flush & ~stall & (squash_cnt == 3'd0);
  assign legal_accept = accept & ~opcode_high;
  // A jump is only recognised when the full opcode is 15, not merely its low nibble.
  assign squash_load  = (legal_accept & (op4 == 4'd15)) | branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      squash_cnt <= 3'd0;
      illegal    <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      squash_cnt <= 3'd0;
    end else if (!stall) begin
      valid_q <= legal_accept;
      ctrl_q  <= legal_accept ? dec : '0;
      if (accept && opcode_high) begin
        illegal <= 1'b1;
      end
      if (squash_load) begin
        squash_cnt <= SQUASH_LOAD;
      end else if (squash_cnt != 3'd0) begin
        squash_cnt <= squash_cnt - 3'd1;
      end
    end
  end

  assign out_valid  = valid_q;
  assign reg_dst    = ctrl_q.reg_dst;
  assign jump       = ctrl_q.jump;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src    = ctrl_q.alu_src;
  assign reg_write  = ctrl_q.reg_write;
  assign beq        = ctrl_q.beq;
  assign bne        = ctrl_q.bne;
  assign mem_op     = ctrl_q.mem_op;
  assign alu_op     = ALU_OP_W'(ctrl_q.alu);
  assign squashing  = (squash_cnt != 3'd0);

endmodule

`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the decoder, squash and illegal rules.
`default_nettype none

module tb_pipelined_control_unit;

  localparam int OPCODE_W = 5;
  localparam int ALU_OP_W = 6;
  localparam int SQ       = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic [OPCODE_W-1:0] opcode = '0;
  logic                stall = 1'b0;
  logic                flush = 1'b0;
  logic                branch_taken = 1'b0;
  logic                out_valid, reg_dst, jump, mem_to_reg, alu_src, reg_write, beq, bne;
  logic [1:0]          mem_op;
  logic [ALU_OP_W-1:0] alu_op;
  logic                illegal, squashing;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [15:0] m_word = '0;
  int          m_sq   = 0;
  logic        m_ill  = 1'b0;

  pipelined_control_unit #(
    .OPCODE_W(OPCODE_W), .ALU_OP_W(ALU_OP_W), .SQUASH_CYCLES(SQ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode), .stall(stall),
    .flush(flush), .branch_taken(branch_taken), .out_valid(out_valid), .reg_dst(reg_dst),
    .jump(jump), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .reg_write(reg_write),
    .beq(beq), .bne(bne), .mem_op(mem_op), .alu_op(alu_op), .illegal(illegal),
    .squashing(squashing)
  );

  always #5 clk = ~clk;

  // Word layout: {valid, reg_dst, jump, mem_to_reg, alu_src, reg_write, beq, bne, mem_op, alu_op[5:0]}
  function automatic logic [15:0] ref_decode(int op);
    logic       rd = 0, jp = 0, m2r = 0, as = 0, rw = 0, bq = 0, bn = 0;
    logic [1:0] mo = 2'b00;
    int         alu = 0;
    case (op)
      0, 2:          begin rd = 1; rw = 1; alu = op / 2; end
      1, 3:          begin as = 1; rw = 1; alu = op / 2; end
      4, 5, 6, 7, 8: begin rd = 1; rw = 1; alu = op - 2; end
      9:             begin rw = 1; alu = 7; end
      10:            begin as = 1; rw = 1; alu = 8; end
      11:            begin mo = 2'b01; m2r = 1; rw = 1; as = 1; end
      12:            begin mo = 2'b10; as = 1; end
      13:            begin bq = 1; alu = 1; end
      14:            begin bn = 1; alu = 1; end
      default:       jp = 1;
    endcase
    return {1'b1, rd, jp, m2r, as, rw, bq, bn, mo, 6'(alu)};
  endfunction

  function automatic logic [15:0] dut_word();
    return {out_valid, reg_dst, jump, mem_to_reg, alu_src, reg_write, beq, bne, mem_op, alu_op};
  endfunction

  function automatic void model_reset();
    m_word = '0;
    m_sq   = 0;
    m_ill  = 1'b0;
  endfunction

  // Advance one clock edge, update the model from the inputs seen at that edge, settle.
  task automatic step();
    bit acc;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      m_word = '0;
      m_sq   = 0;
    end else if (!stall) begin
      acc    = in_valid && (m_sq == 0);
      m_word = (acc && opcode < 16) ? ref_decode(int'(opcode)) : 16'h0;
      if (acc && opcode >= 16) m_ill = 1'b1;
      if ((acc && opcode == 15) || branch_taken) m_sq = SQ;
      else if (m_sq > 0) m_sq = m_sq - 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; opcode = '0; stall = 0; flush = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #1;
    checks++; if (dut_word() !== 16'h0) $display("FAIL reset_word got=%h exp=%h", dut_word(), 16'h0); else passed++;
    checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", illegal); else passed++;
    checks++; if (squashing !== 1'b0) $display("FAIL reset_squashing got=%b exp=0", squashing); else passed++;
    model_reset();
    @(negedge clk);
    in_valid = 1; opcode = 5'd9;
    rst_n = 1;
    #1;
    checks++; if (dut_word() !== 16'h0) $display("FAIL reset_release_no_edge got=%h exp=0", dut_word()); else passed++;
    step();
    checks++; if (dut_word() !== ref_decode(9)) $display("FAIL first_after_reset got=%h exp=%h", dut_word(), ref_decode(9)); else passed++;
    idle_inputs();
  endtask

  task automatic test_sweep();
    do_reset();
    for (int op = 0; op < 16; op++) begin
      in_valid = 1; opcode = OPCODE_W'(op);
      step();
      checks++;
      if (dut_word() !== ref_decode(op))
        $display("FAIL sweep_op%0d got=%h exp=%h", op, dut_word(), ref_decode(op));
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_jump_squash();
    do_reset();
    in_valid = 1; opcode = 5'd15;
    step();
    checks++; if (jump !== 1'b1 || out_valid !== 1'b1) $display("FAIL jump_decode got jump=%b valid=%b exp 1/1", jump, out_valid); else passed++;
    checks++; if (squashing !== 1'b1) $display("FAIL jump_squashing0 got=%b exp=1", squashing); else passed++;
    opcode = 5'd0;
    step();
    checks++; if (dut_word() !== 16'h0) $display("FAIL squash_bubble1 got=%h exp=0", dut_word()); else passed++;
    checks++; if (squashing !== 1'b1) $display("FAIL squash_squashing1 got=%b exp=1", squashing); else passed++;
    opcode = 5'd1;
    step();
    checks++; if (dut_word() !== 16'h0) $display("FAIL squash_bubble2 got=%h exp=0", dut_word()); else passed++;
    checks++; if (squashing !== 1'b0) $display("FAIL squash_done got=%b exp=0", squashing); else passed++;
    opcode = 5'd2;
    step();
    checks++;
    if (out_valid !== 1'b1 || reg_dst !== 1'b1 || alu_op !== 6'd1)
      $display("FAIL after_squash got valid=%b reg_dst=%b alu_op=%0d exp 1/1/1", out_valid, reg_dst, alu_op);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1; opcode = 5'd4;
    step();
    checks++; if (alu_op !== 6'd2) $display("FAIL stall_pre got=%0d exp=2", alu_op); else passed++;
    opcode = 5'd5; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (alu_op !== 6'd2 || out_valid !== 1'b1) $display("FAIL stall_hold%0d got alu=%0d valid=%b exp 2/1", i, alu_op, out_valid); else passed++;
    end
    stall = 0;
    step();
    checks++; if (alu_op !== 6'd3) $display("FAIL stall_release got=%0d exp=3", alu_op); else passed++;
    idle_inputs();
  endtask

  task automatic test_branch_flush();
    do_reset();
    in_valid = 1; opcode = 5'd0; branch_taken = 1; flush = 1;
    step();
    checks++; if (dut_word() !== 16'h0 || squashing !== 1'b0) $display("FAIL branch_flush got=%h sq=%b exp 0/0", dut_word(), squashing); else passed++;
    branch_taken = 0; flush = 0; opcode = 5'd9;
    step();
    checks++; if (dut_word() !== ref_decode(9)) $display("FAIL branch_flush_next got=%h exp=%h", dut_word(), ref_decode(9)); else passed++;
    idle_inputs();
  endtask

  task automatic test_illegal();
    do_reset();
    in_valid = 1; opcode = 5'd16;
    step();
    checks++; if (dut_word() !== 16'h0 || illegal !== 1'b1) $display("FAIL illegal_set got=%h ill=%b exp 0/1", dut_word(), illegal); else passed++;
    opcode = 5'd0;
    step();
    checks++; if (dut_word() !== ref_decode(0)) $display("FAIL illegal_next got=%h exp=%h", dut_word(), ref_decode(0)); else passed++;
    checks++; if (illegal !== 1'b1) $display("FAIL illegal_sticky got=%b exp=1", illegal); else passed++;
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1; opcode = 5'd15;
    step();
    opcode = 5'd3;
    #2 rst_n = 0;
    #1;
    checks++; if (dut_word() !== 16'h0 || squashing !== 1'b0 || illegal !== 1'b0)
      $display("FAIL async_reset got=%h sq=%b ill=%b exp 0/0/0", dut_word(), squashing, illegal);
    else passed++;
    model_reset();
    #2 rst_n = 1;
    step();
    checks++; if (dut_word() !== ref_decode(3)) $display("FAIL async_reset_next got=%h exp=%h", dut_word(), ref_decode(3)); else passed++;
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      opcode       = ($urandom_range(0, 19) == 0) ? OPCODE_W'($urandom_range(16, 31))
                                                  : OPCODE_W'($urandom_range(0, 15));
      stall        = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 15) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      step();
      checks++; if (dut_word() !== m_word) $display("FAIL rand_word cyc=%0d got=%h exp=%h", i, dut_word(), m_word); else passed++;
      checks++; if (squashing !== (m_sq != 0)) $display("FAIL rand_squashing cyc=%0d got=%b exp=%b", i, squashing, (m_sq != 0)); else passed++;
      checks++; if (illegal !== m_ill) $display("FAIL rand_illegal cyc=%0d got=%b exp=%b", i, illegal, m_ill); else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_jump_squash();
    test_stall();
    test_branch_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 Parameter OPCODE_W, default 4, opcode width; legal range 4..8.
REQ-002 Parameter ALU_OP_W, default 4, alu_op width; legal range 4..8.
REQ-003 Parameter SQUASH_CYCLES, default 2, number of issue slots killed after a control transfer; legal range 0..7.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  opcode carries a real instruction this cycle.
REQ-007 opcode  in  OPCODE_W  instruction opcode.
REQ-008 stall  in  1  hold all registered outputs and internal state.
REQ-009 flush  in  1  kill the incoming instruction and cancel any pending squash.
REQ-010 branch_taken  in  1  one-cycle pulse from execute: the branch resolved as taken.
REQ-011 out_valid  out  1  registered control word is a real instruction.
REQ-012 reg_dst, jump, mem_to_reg, alu_src, reg_write, beq, bne  out  1 each  registered control flags.
REQ-013 mem_op  out  2  00 none, 01 load, 10 store.
REQ-014 alu_op  out  ALU_OP_W  ALU function, zero-extended from the 4-bit table code.
REQ-015 illegal  out  1  sticky: an opcode >= 16 was accepted.
REQ-016 squashing  out  1  high while the squash counter is non-zero.

Function
REQ-017 Decode table (unlisted fields SHALL be 0): 0: reg_dst,reg_write, alu 0. 1: alu_src,reg_write, alu 0. 2: reg_dst,reg_write, alu 1. 3: alu_src,reg_write, alu 1. 4-8: reg_dst,reg_write, alu 2..6 (op-2). 9: reg_write, alu 7. 10: alu_src,reg_write, alu 8. 11: mem_op 01,mem_to_reg,reg_write,alu_src, alu 0. 12: mem_op 10,alu_src, alu 0. 13: beq, alu 1. 14: bne, alu 1. 15: jump.
REQ-018 Bubble: out_valid and every control output 0.
REQ-019 Accept condition: in_valid & !flush & !stall & squash_cnt==0.
REQ-020 Each rising edge with stall=0 and flush=0 SHALL load the decoded word with out_valid=1 if accepted, else a bubble.
REQ-021 Opcode >= 16 accepted: load a bubble, set illegal.
REQ-022 Latency SHALL be exactly one cycle from opcode sample to registered outputs.
REQ-023 stall=1, flush=0: outputs, squash counter and illegal hold their values; branch_taken is ignored.
REQ-024 flush=1 SHALL load a bubble and clear the squash counter regardless of stall and branch_taken.
REQ-025 Squash counter (3 bits) SHALL load SQUASH_CYCLES when an opcode-15 instruction is accepted or when branch_taken=1 on a non-stalled, non-flushed edge.
REQ-026 Otherwise, on a non-stalled edge with the counter non-zero, the counter SHALL decrement by 1 and the slot is a bubble.
REQ-027 Load SHALL take priority over decrement when both apply on the same edge.
REQ-028 SQUASH_CYCLES=0: no slot is ever squashed; the next instruction is accepted normally.
REQ-029 squashing SHALL equal (squash_cnt != 0), combinationally from the register.
REQ-030 illegal SHALL be cleared only by reset.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock edge, force a bubble on all outputs, set the squash counter to 0 and clear illegal.
REQ-032 Reset asserted mid-squash or mid-stall SHALL discard that state; the first accepted instruction after release is the first one presented with in_valid=1.
REQ-033 Outputs SHALL first change on the first rising edge after rst_n deasserts.

Verification
REQ-034 Sweep opcodes 0..15 with in_valid=1 -> each registered word matches REQ-017 one cycle later; out_valid=1.
REQ-035 Opcode 15 then opcodes 0,1,2 with SQUASH_CYCLES=2 -> jump=1, then two bubbles with squashing=1, then opcode 2 decoded with alu_op=1 and reg_dst=1.
REQ-036 Opcode 4 held with stall=1 for 3 cycles, then opcode 5 -> alu_op stays 2 during the stall; alu_op=3 one cycle after release.
REQ-037 branch_taken=1 and flush=1 on the same edge -> bubble, squashing=0; the next instruction is accepted.
REQ-038 OPCODE_W=5, opcode 16 -> bubble, illegal=1 and staying 1; a later opcode 0 decodes normally.
REQ-039 rst_n pulsed low mid-squash, between clock edges -> all outputs 0 and squashing=0 before the next edge.
